nibble_counter_ctrl: RTL and testbench

// - Upstream source for the 7-segment nibble decoder: drives its a,b,c,d inputs (a = MSB).
// - Holds a 4-bit count that changes on debounced pushbuttons (up/down), loads from 4 switches,
//   or auto-increments on a prescaled tick; emits a 1-cycle wrap pulse.

---
 rtl/nibble_counter_ctrl.sv | 155 +++++++++++++++
 tb/tb_nibble_counter_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_counter_ctrl.sv
// 4-bit up/down/load/auto counter feeding the 7-segment nibble decoder (a = MSB).
// Optional BCD_WRAP_EN macro restricts the count range to 0..9 and clamps loads above 9.
module nibble_counter_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_DIV        = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_ld,
  input  logic [3:0] sw,
  input  logic       auto_en,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       wrap
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int PW = $clog2(AUTO_DIV);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(AUTO_DIV - 1);
`ifdef BCD_WRAP_EN
  localparam logic [3:0] MAX_COUNT = 4'd9;
`else
  localparam logic [3:0] MAX_COUNT = 4'd15;
`endif

  typedef enum logic {MANUAL, AUTO} mode_e;

  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    stable_q, stable_d, stable_dly_q, stable_dly_d;
  logic [2:0]    armed_q, armed_d;
  logic [2:0]    pulse;
  logic [CW-1:0] deb_cnt_q [3];
  logic [CW-1:0] deb_cnt_d [3];
  logic [CW-1:0] arm_cnt_q [3];
  logic [CW-1:0] arm_cnt_d [3];

  mode_e         mode_q, mode_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [3:0]    count_q, count_d, load_val;
  logic          wrap_q, wrap_d;
  logic          up_p, dn_p, ld_p, inc, dec;

  assign raw = {btn_ld, btn_dn, btn_up};

  // A button only acts once it has been seen released for a full debounce window
  // after reset, so a press held through reset is ignored until pressed again.
  always_comb begin
    sync1_d      = raw;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    armed_d      = armed_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      arm_cnt_d[i] = arm_cnt_q[i];
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) stable_d[i] = sync2_q[i];
        else deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
      if (!armed_q[i]) begin
        if (sync1_q[i] | sync2_q[i]) begin
          arm_cnt_d[i] = '0;
        end else if (arm_cnt_q[i] == DEB_LAST) begin
          armed_d[i]   = 1'b1;
          arm_cnt_d[i] = '0;
        end else begin
          arm_cnt_d[i] = arm_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign pulse = stable_q & ~stable_dly_q & armed_q;
  assign up_p  = pulse[0];
  assign dn_p  = pulse[1];
  assign ld_p  = pulse[2];

  // Priority: load, then a lone up or down, then the auto tick (lost on any button pulse).
  always_comb begin
    mode_d  = auto_en ? AUTO : MANUAL;
    presc_d = '0;
    if (mode_d == AUTO && presc_q != PRE_LAST) presc_d = presc_q + 1'b1;
    tick = (mode_q == AUTO) && (presc_q == PRE_LAST);
`ifdef BCD_WRAP_EN
    load_val = (sw > MAX_COUNT) ? MAX_COUNT : sw;
`else
    load_val = sw;
`endif
    inc     = (up_p & ~dn_p) | (tick & ~up_p & ~dn_p);
    dec     = dn_p & ~up_p;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (ld_p) begin
      count_d = load_val;
      presc_d = '0;
    end else if (inc) begin
      if (count_q == MAX_COUNT) begin
        count_d = 4'd0;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end else if (dec) begin
      if (count_q == 4'd0) begin
        count_d = MAX_COUNT;
        wrap_d  = 1'b1;
      end else begin
        count_d = count_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      armed_q      <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
        arm_cnt_q[i] <= '0;
      end
      mode_q  <= MANUAL;
      presc_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      armed_q      <= armed_d;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
        arm_cnt_q[i] <= arm_cnt_d[i];
      end
      mode_q  <= mode_d;
      presc_q <= presc_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign {a, b, c, d} = count_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_nibble_counter_ctrl.sv
// Self-checking bench for nibble_counter_ctrl: directed scenarios plus random buttons
// against a cycle-level behavioural model. Honours BCD_WRAP_EN when defined.
module tb_nibble_counter_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 8;
`ifdef BCD_WRAP_EN
  localparam int MAXV = 9;
`else
  localparam int MAXV = 15;
`endif

  logic       clk = 1'b0;
  logic       rst, btn_up, btn_dn, btn_ld, auto_en;
  logic [3:0] sw;
  logic       a, b, c, d, wrap;
  logic [3:0] cnt_obs;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  int m_count, m_since;
  bit m_wrap;
  bit m_stable [3];
  bit m_armed  [3];
  bit m_pend   [3];
  bit m_dly1   [3];
  bit m_dly2   [3];
  int m_run    [3];
  int m_low    [3];

  always #5 clk = ~clk;

  assign cnt_obs = {a, b, c, d};

  nibble_counter_ctrl #(.DEBOUNCE_CYCLES(DEB), .AUTO_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .btn_ld(btn_ld),
    .sw(sw), .auto_en(auto_en), .a(a), .b(b), .c(c), .d(d), .wrap(wrap)
  );

  // Advances the model by one rising edge using the inputs the DUT sees at that edge.
  task automatic model_edge();
    bit r [3];
    bit p_up, p_dn, p_ld, fire, rose;
    int in_v;
    if (rst) begin
      m_count = 0; m_since = 0; m_wrap = 0;
      for (int i = 0; i < 3; i++) begin
        m_stable[i] = 0; m_armed[i] = 0; m_pend[i] = 0;
        m_dly1[i] = 0; m_dly2[i] = 0; m_run[i] = 0; m_low[i] = 0;
      end
    end else begin
      r[0] = btn_up; r[1] = btn_dn; r[2] = btn_ld;
      p_up = m_pend[0]; p_dn = m_pend[1]; p_ld = m_pend[2];
      fire = (m_since == DIV - 1);
      m_wrap = 0;
      if (p_ld) begin
        m_count = (int'(sw) > MAXV) ? MAXV : int'(sw);
      end else if (p_up != p_dn) begin
        if (p_up) begin
          m_wrap = (m_count == MAXV); m_count = (m_count + 1) % (MAXV + 1);
        end else begin
          m_wrap = (m_count == 0); m_count = (m_count + MAXV) % (MAXV + 1);
        end
      end else if (!p_up && fire) begin
        m_wrap = (m_count == MAXV); m_count = (m_count + 1) % (MAXV + 1);
      end
      m_since = (p_ld || fire || !auto_en) ? 0 : m_since + 1;
      for (int i = 0; i < 3; i++) begin
        in_v = m_dly2[i];
        if (!m_armed[i]) begin
          if (!m_dly1[i] && !m_dly2[i]) begin
            m_low[i]++;
            if (m_low[i] == DEB) m_armed[i] = 1;
          end else m_low[i] = 0;
        end
        rose = 0;
        if (in_v != int'(m_stable[i])) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_stable[i] = bit'(in_v); m_run[i] = 0; rose = bit'(in_v);
          end
        end else m_run[i] = 0;
        m_pend[i] = rose && m_armed[i];
        m_dly2[i] = m_dly1[i];
        m_dly1[i] = r[i];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic press(input bit up, input bit dn, input bit ld, input int hold);
    btn_up = up; btn_dn = dn; btn_ld = ld;
    repeat (hold) step();
    btn_up = 0; btn_dn = 0; btn_ld = 0;
    repeat (DEB + 4) step();
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      btn_up = 1'($urandom); btn_dn = 1'($urandom); btn_ld = 1'($urandom);
      sw = 4'($urandom); auto_en = 1'($urandom);
      step();
      checks++;
      if (cnt_obs !== 4'd0 || wrap !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_hold: count=%h wrap=%b expected count=0 wrap=0", cnt_obs, wrap);
      end
    end
    rst = 0; btn_up = 0; btn_dn = 0; btn_ld = 0; auto_en = 0; sw = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (cnt_obs !== 4'd0 || wrap !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_release: count=%h wrap=%b expected count=0 wrap=0", cnt_obs, wrap);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_c;
    btn_up = 1; step();
    btn_up = 0; step();
    btn_up = 1;
    for (int i = 3; i <= 12; i++) begin
      step();
      exp_c = (i >= 9) ? 4'd1 : 4'd0;
      checks++;
      if (cnt_obs !== exp_c || cnt_obs !== 4'(m_count)) begin
        failures++;
        $display("[TB] FAIL bounce_step%0d: count=%h expected %h (model %0d)", i, cnt_obs, exp_c, m_count);
      end
    end
    btn_up = 0;
    repeat (DEB + 4) step();
    checks++;
    if (cnt_obs !== 4'd1) begin
      failures++;
      $display("[TB] FAIL bounce_final: count=%h expected 1", cnt_obs);
    end
  endtask

  task automatic test_wrap_down();
    int wraps = 0;
    press(0, 1, 0, 8);
    checks++;
    if (cnt_obs !== 4'd0) begin
      failures++;
      $display("[TB] FAIL down_to_zero: count=%h expected 0", cnt_obs);
    end
    btn_dn = 1;
    for (int i = 0; i < 8 + DEB + 4; i++) begin
      if (i == 8) btn_dn = 0;
      step();
      if (wrap === 1'b1) wraps++;
      checks++;
      if (cnt_obs !== 4'(m_count) || wrap !== m_wrap) begin
        failures++;
        $display("[TB] FAIL down_wrap_cycle: count=%h wrap=%b expected count=%h wrap=%b", cnt_obs, wrap, 4'(m_count), m_wrap);
      end
    end
    checks++;
    if (cnt_obs !== 4'(MAXV) || wraps != 1) begin
      failures++;
      $display("[TB] FAIL down_wrap: count=%h wraps=%0d expected count=%h wraps=1", cnt_obs, wraps, 4'(MAXV));
    end
  endtask

  task automatic test_load_priority();
    logic [3:0] exp_c;
    sw = 4'b1010;
    exp_c = (MAXV == 9) ? 4'd9 : 4'b1010;
    press(1, 0, 1, 8);
    checks++;
    if (cnt_obs !== exp_c || wrap !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_beats_up: count=%h wrap=%b expected count=%h wrap=0", cnt_obs, wrap, exp_c);
    end
  endtask

  task automatic test_wrap_up();
    int wraps = 0;
    sw = 4'hF;
    press(0, 0, 1, 8);
    checks++;
    if (cnt_obs !== 4'(MAXV)) begin
      failures++;
      $display("[TB] FAIL load_max: count=%h expected %h", cnt_obs, 4'(MAXV));
    end
    btn_up = 1;
    for (int i = 0; i < 8 + DEB + 4; i++) begin
      if (i == 8) btn_up = 0;
      step();
      if (wrap === 1'b1) wraps++;
    end
    checks++;
    if (cnt_obs !== 4'd0 || wraps != 1) begin
      failures++;
      $display("[TB] FAIL up_wrap: count=%h wraps=%0d expected count=0 wraps=1", cnt_obs, wraps);
    end
  endtask

  task automatic test_auto();
    sw = 4'd0;
    press(0, 0, 1, 8);
    auto_en = 1;
    for (int i = 1; i <= 40; i++) begin
      step();
      checks++;
      if (cnt_obs !== 4'(i / 8) || cnt_obs !== 4'(m_count)) begin
        failures++;
        $display("[TB] FAIL auto_cycle%0d: count=%h expected %h", i, cnt_obs, 4'(i / 8));
      end
    end
    auto_en = 0;
    repeat (3) step();
    checks++;
    if (cnt_obs !== 4'd5) begin
      failures++;
      $display("[TB] FAIL auto_stop: count=%h expected 5", cnt_obs);
    end
  endtask

  task automatic test_cancel();
    sw = 4'b0111;
    press(0, 0, 1, 8);
    btn_up = 1; btn_dn = 1;
    for (int i = 0; i < 8 + DEB + 4; i++) begin
      if (i == 8) begin btn_up = 0; btn_dn = 0; end
      step();
      checks++;
      if (cnt_obs !== 4'b0111 || wrap !== 1'b0) begin
        failures++;
        $display("[TB] FAIL up_dn_cancel: count=%h wrap=%b expected count=7 wrap=0", cnt_obs, wrap);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    btn_up = 1;
    repeat (3) step();
    rst = 1;
    repeat (2) step();
    rst = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (cnt_obs !== 4'd0 || wrap !== 1'b0) begin
        failures++;
        $display("[TB] FAIL held_through_reset: count=%h wrap=%b expected count=0 wrap=0", cnt_obs, wrap);
      end
    end
    btn_up = 0;
    repeat (10) step();
    press(1, 0, 0, 8);
    checks++;
    if (cnt_obs !== 4'd1 || cnt_obs !== 4'(m_count)) begin
      failures++;
      $display("[TB] FAIL repress_after_reset: count=%h expected 1", cnt_obs);
    end
  endtask

  task automatic test_random();
    bit lvl  [3];
    int left [3];
    for (int i = 0; i < 3; i++) begin lvl[i] = 0; left[i] = 0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (left[i] == 0) begin
          lvl[i]  = 1'($urandom);
          left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 14);
        end
        left[i]--;
      end
      btn_up = lvl[0]; btn_dn = lvl[1]; btn_ld = lvl[2];
      if ($urandom_range(0, 15) == 0) sw = 4'($urandom);
      if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
      rst = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if (cnt_obs !== 4'(m_count) || wrap !== m_wrap) begin
        failures++;
        $display("[TB] FAIL random_cycle%0d: count=%h wrap=%b expected count=%h wrap=%b", cyc, cnt_obs, wrap, 4'(m_count), m_wrap);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; btn_up = 0; btn_dn = 0; btn_ld = 0; sw = 0; auto_en = 0;
    #1;
    test_reset();
    test_bounce();
    test_wrap_down();
    test_load_priority();
    test_wrap_up();
    test_auto();
    test_cancel();
    test_reset_mid_press();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
